// File: rtl/uart_chk_pkg.sv
// Shared types for the UART receive-stream checker.
package uart_chk_pkg;

  typedef enum logic [1:0] {
    IDLE,
    HUNT,
    TRACK,
    DONE
  } state_e;

  typedef enum logic {
    PATTERN,
    LOOPBACK
  } mode_e;

endpackage

// File: rtl/uart_lb_fifo.sv
// Register FIFO holding transmitted words until the matching receive word arrives.
// Any depth works; a push is still accepted when full if a pop happens in the same cycle.
module uart_lb_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic              full,
  output logic              empty,
  output logic [DATA_W-1:0] head
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [AW-1:0] LAST  = AW'(DEPTH - 1);
  localparam logic [CW-1:0] CAP   = CW'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     count;
  logic              do_push, do_pop;

  assign full    = (count == CAP);
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_seq_checker.sv
// Checks the received byte stream against a programmed pattern or the transmitted words.
//   state | meaning
//   IDLE  | not armed (or armed with an unusable pattern length)
//   HUNT  | pattern: waiting for exp[0]; loopback: comparing every rx word
//   TRACK | pattern: partway through the sequence, seq_idx is next entry
//   DONE  | single-shot pattern matched, rx ignored until re-armed
module uart_seq_checker
  import uart_chk_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8,
  parameter int CNT_W  = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       mode,
  input  logic                       cont,
  input  logic                       cfg_wr_en,
  input  logic [$clog2(DEPTH)-1:0]   cfg_wr_addr,
  input  logic [DATA_W-1:0]          cfg_wr_data,
  input  logic [$clog2(DEPTH+1)-1:0] cfg_len,
  input  logic                       arm,
  input  logic                       clr_cnt,
  input  logic                       tx_valid,
  input  logic [DATA_W-1:0]          tx_data,
  input  logic                       rx_valid,
  input  logic [DATA_W-1:0]          rx_data,
  output logic                       busy,
  output logic                       match_pulse,
  output logic                       err_pulse,
  output logic [CNT_W-1:0]           match_cnt,
  output logic [CNT_W-1:0]           err_cnt,
  output logic [$clog2(DEPTH+1)-1:0] seq_idx,
  output logic                       ovf,
  output logic                       unexp
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);
  localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  logic [DATA_W-1:0] exp_mem [DEPTH];

  state_e            state_q, state_d;
  mode_e             mode_q, mode_d;
  logic              cont_q, cont_d;
  logic [LW-1:0]     len_q, len_d, idx_q, idx_d;
  logic [CNT_W-1:0]  mcnt_d, ecnt_d, mbase, ebase;
  logic              mp_d, ep_d, ovf_d, unexp_d, busy_d;
  logic              arm_ok, m_inc, e_inc, set_ovf, set_unexp;
  logic              push, pop, full, empty;
  logic [DATA_W-1:0] head, exp_cur, exp_first;

  uart_lb_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (tx_data),
    .pop       (pop),
    .full      (full),
    .empty     (empty),
    .head      (head)
  );

  always_ff @(posedge clk) begin
    if (!rst && cfg_wr_en && !busy) exp_mem[cfg_wr_addr] <= cfg_wr_data;
  end

  assign exp_cur   = exp_mem[idx_q[AW-1:0]];
  assign exp_first = exp_mem[0];
  assign arm_ok    = arm && (mode || (cfg_len != '0 && cfg_len <= DEPTH_L));

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    cont_d    = cont_q;
    len_d     = len_q;
    idx_d     = idx_q;
    mcnt_d    = match_cnt;
    ecnt_d    = err_cnt;
    ovf_d     = ovf;
    unexp_d   = unexp;
    mp_d      = 1'b0;
    ep_d      = 1'b0;
    m_inc     = 1'b0;
    e_inc     = 1'b0;
    set_ovf   = 1'b0;
    set_unexp = 1'b0;
    push      = 1'b0;
    pop       = 1'b0;
    mbase     = clr_cnt ? '0 : match_cnt;
    ebase     = clr_cnt ? '0 : err_cnt;

    if (arm_ok) begin
      state_d = HUNT;
      mode_d  = mode_e'(mode);
      cont_d  = cont;
      len_d   = cfg_len;
      idx_d   = '0;
    end else begin
      if ((state_q == HUNT || state_q == TRACK) && mode_q == LOOPBACK) begin
        if (empty) begin
          // Bypass: an empty FIFO compares straight against the word being sent.
          if (rx_valid && tx_valid) begin
            m_inc = (rx_data == tx_data);
            e_inc = !m_inc;
            mp_d  = m_inc;
            ep_d  = e_inc;
          end else if (rx_valid) begin
            set_unexp = 1'b1;
            e_inc     = 1'b1;
          end else if (tx_valid) begin
            push = 1'b1;
          end
        end else begin
          if (rx_valid) begin
            pop   = 1'b1;
            m_inc = (rx_data == head);
            e_inc = !m_inc;
            mp_d  = m_inc;
            ep_d  = e_inc;
          end
          if (tx_valid) begin
            if (full && !rx_valid) set_ovf = 1'b1;
            else                   push    = 1'b1;
          end
        end
      end else if (state_q == HUNT && rx_valid) begin
        if (rx_data == exp_first) begin
          if (len_q == LW'(1)) begin
            m_inc   = 1'b1;
            mp_d    = 1'b1;
            idx_d   = '0;
            state_d = cont_q ? HUNT : DONE;
          end else begin
            idx_d   = LW'(1);
            state_d = TRACK;
          end
        end
      end else if (state_q == TRACK && rx_valid) begin
        if (rx_data == exp_cur) begin
          if (idx_q == len_q - LW'(1)) begin
            m_inc   = 1'b1;
            mp_d    = 1'b1;
            idx_d   = '0;
            state_d = cont_q ? HUNT : DONE;
          end else begin
            idx_d = idx_q + LW'(1);
          end
        end else begin
          e_inc = 1'b1;
          ep_d  = 1'b1;
          if (rx_data == exp_first) begin
            idx_d = LW'(1);
          end else begin
            idx_d   = '0;
            state_d = HUNT;
          end
        end
      end

      mcnt_d  = m_inc ? sat_inc(mbase) : mbase;
      ecnt_d  = e_inc ? sat_inc(ebase) : ebase;
      ovf_d   = (ovf && !clr_cnt) || set_ovf;
      unexp_d = (unexp && !clr_cnt) || set_unexp;
    end

    busy_d = (state_d == HUNT || state_d == TRACK);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      mode_q      <= PATTERN;
      cont_q      <= 1'b0;
      len_q       <= '0;
      idx_q       <= '0;
      match_cnt   <= '0;
      err_cnt     <= '0;
      match_pulse <= 1'b0;
      err_pulse   <= 1'b0;
      ovf         <= 1'b0;
      unexp       <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      cont_q      <= cont_d;
      len_q       <= len_d;
      idx_q       <= idx_d;
      match_cnt   <= mcnt_d;
      err_cnt     <= ecnt_d;
      match_pulse <= mp_d;
      err_pulse   <= ep_d;
      ovf         <= ovf_d;
      unexp       <= unexp_d;
      busy        <= busy_d;
    end
  end

  assign seq_idx = idx_q;

endmodule

// File: tb/tb_uart_seq_checker.sv
// Directed and randomized checks of uart_seq_checker against a queue-based reference model.
module tb_uart_seq_checker;

  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int CW    = 2;
  localparam int AW    = 2;
  localparam int LW    = 3;
  localparam int CMAX  = 3;

  localparam int P_IDLE  = 0;
  localparam int P_HUNT  = 1;
  localparam int P_TRACK = 2;
  localparam int P_DONE  = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          mode = 1'b0, cont = 1'b0, cfg_wr_en = 1'b0;
  logic [AW-1:0] cfg_wr_addr = '0;
  logic [DW-1:0] cfg_wr_data = '0;
  logic [LW-1:0] cfg_len = '0;
  logic          arm = 1'b0, clr_cnt = 1'b0, tx_valid = 1'b0, rx_valid = 1'b0;
  logic [DW-1:0] tx_data = '0, rx_data = '0;
  logic          busy, match_pulse, err_pulse, ovf, unexp;
  logic [CW-1:0] match_cnt, err_cnt;
  logic [LW-1:0] seq_idx;

  int errors = 0;
  int checks = 0;

  // reference model state
  int            ph = P_IDLE;
  int            m_pos = 0, m_len = 0, m_match = 0, m_err = 0;
  bit            m_lb = 0, m_cont = 0, m_mp = 0, m_ep = 0, m_ovf = 0, m_unexp = 0;
  logic [DW-1:0] m_exp [DEPTH];
  logic [DW-1:0] q [$];

  uart_seq_checker #(.DATA_W(DW), .DEPTH(DEPTH), .CNT_W(CW)) dut (
    .clk         (clk),
    .rst         (rst),
    .mode        (mode),
    .cont        (cont),
    .cfg_wr_en   (cfg_wr_en),
    .cfg_wr_addr (cfg_wr_addr),
    .cfg_wr_data (cfg_wr_data),
    .cfg_len     (cfg_len),
    .arm         (arm),
    .clr_cnt     (clr_cnt),
    .tx_valid    (tx_valid),
    .tx_data     (tx_data),
    .rx_valid    (rx_valid),
    .rx_data     (rx_data),
    .busy        (busy),
    .match_pulse (match_pulse),
    .err_pulse   (err_pulse),
    .match_cnt   (match_cnt),
    .err_cnt     (err_cnt),
    .seq_idx     (seq_idx),
    .ovf         (ovf),
    .unexp       (unexp)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
    checks++;
    assert (got === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, expv);
    end
  endtask

  function automatic int sat(input int v);
    return (v >= CMAX) ? CMAX : v + 1;
  endfunction

  task automatic model_step();
    bit active, hit, miss, bypass;
    int pre;
    m_mp = 0;
    m_ep = 0;
    if (rst) begin
      ph = P_IDLE; m_pos = 0; m_len = 0; m_match = 0; m_err = 0;
      m_lb = 0; m_cont = 0; m_ovf = 0; m_unexp = 0;
      q.delete();
      return;
    end
    active = (ph == P_HUNT || ph == P_TRACK);
    if (cfg_wr_en && !active) m_exp[cfg_wr_addr] = cfg_wr_data;
    if (arm && (mode || (cfg_len >= 1 && cfg_len <= DEPTH))) begin
      m_lb = mode; m_cont = cont; m_len = int'(cfg_len); m_pos = 0; ph = P_HUNT;
      return;
    end
    if (clr_cnt) begin
      m_match = 0; m_err = 0; m_ovf = 0; m_unexp = 0;
    end
    hit = 0;
    miss = 0;
    if (active && m_lb) begin
      pre = q.size();
      bypass = rx_valid && tx_valid && pre == 0;
      if (rx_valid) begin
        if (bypass) begin
          hit = (rx_data == tx_data); miss = !hit;
          m_mp = hit; m_ep = miss;
        end else if (pre == 0) begin
          m_unexp = 1; miss = 1;
        end else begin
          hit = (rx_data == q.pop_front()); miss = !hit;
          m_mp = hit; m_ep = miss;
        end
      end
      if (tx_valid && !bypass) begin
        if (pre == DEPTH && !rx_valid) m_ovf = 1;
        else q.push_back(tx_data);
      end
    end else if (active && rx_valid) begin
      if (ph == P_HUNT) begin
        if (rx_data == m_exp[0]) begin
          m_pos = 1; ph = P_TRACK;
        end
      end else if (rx_data == m_exp[m_pos]) begin
        m_pos++;
      end else begin
        miss = 1; m_ep = 1;
        if (rx_data == m_exp[0]) m_pos = 1;
        else begin m_pos = 0; ph = P_HUNT; end
      end
      if (ph == P_TRACK && m_pos == m_len) begin
        hit = 1; m_mp = 1; m_pos = 0;
        ph = m_cont ? P_HUNT : P_DONE;
      end
    end
    if (hit)  m_match = sat(m_match);
    if (miss) m_err = sat(m_err);
  endtask

  task automatic check_all();
    chk("busy", 32'(busy), 32'(ph == P_HUNT || ph == P_TRACK));
    chk("match_pulse", 32'(match_pulse), 32'(m_mp));
    chk("err_pulse", 32'(err_pulse), 32'(m_ep));
    chk("match_cnt", 32'(match_cnt), 32'(m_match));
    chk("err_cnt", 32'(err_cnt), 32'(m_err));
    chk("seq_idx", 32'(seq_idx), 32'(m_pos));
    chk("ovf", 32'(ovf), 32'(m_ovf));
    chk("unexp", 32'(unexp), 32'(m_unexp));
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check_all();
    rst = 0; arm = 0; clr_cnt = 0; cfg_wr_en = 0; tx_valid = 0; rx_valid = 0;
  endtask

  task automatic wr(input int a, input int d);
    cfg_wr_en = 1; cfg_wr_addr = AW'(a); cfg_wr_data = DW'(d); tick();
  endtask

  task automatic do_arm(input bit md, input bit c, input int l);
    arm = 1; mode = md; cont = c; cfg_len = LW'(l); tick();
  endtask

  task automatic rxw(input int d);
    rx_valid = 1; rx_data = DW'(d); tick();
  endtask

  task automatic txw(input int d);
    tx_valid = 1; tx_data = DW'(d); tick();
  endtask

  task automatic both(input int t, input int r);
    tx_valid = 1; tx_data = DW'(t); rx_valid = 1; rx_data = DW'(r); tick();
  endtask

  task automatic clr();
    clr_cnt = 1; tick();
  endtask

  initial begin
    rst = 1; tick();
    rst = 1; tick();
    chk("reset_match_cnt", 32'(match_cnt), 0);
    chk("reset_busy", 32'(busy), 0);

    wr(0, 'h41); wr(1, 'h42); wr(2, 'h43); wr(3, 'h44);

    do_arm(0, 0, 0);
    chk("arm_len0_ignored", 32'(busy), 0);
    do_arm(0, 0, 5);
    chk("arm_len5_ignored", 32'(busy), 0);

    // single-shot match
    do_arm(0, 0, 3);
    chk("armed_busy", 32'(busy), 1);
    rxw('h41); rxw('h42); rxw('h43);
    chk("single_match_pulse", 32'(match_pulse), 1);
    chk("single_match_cnt", 32'(match_cnt), 1);
    chk("single_done", 32'(busy), 0);
    rxw('h41);
    chk("done_ignores_rx", 32'(seq_idx), 0);

    // restart on mismatch
    clr();
    do_arm(0, 0, 3);
    rxw('h41); rxw('h42); rxw('h41);
    chk("restart_err_pulse", 32'(err_pulse), 1);
    chk("restart_idx", 32'(seq_idx), 1);
    rxw('h42); rxw('h43);
    chk("restart_match_cnt", 32'(match_cnt), 1);
    chk("restart_err_cnt", 32'(err_cnt), 1);

    // continuous single-entry pattern
    wr(0, 'h55);
    clr();
    do_arm(0, 1, 1);
    rxw('h55); rxw('h00); rxw('h55);
    chk("cont_match_cnt", 32'(match_cnt), 2);
    chk("cont_err_cnt", 32'(err_cnt), 0);
    chk("cont_busy", 32'(busy), 1);

    // loopback fill and overflow
    clr();
    do_arm(1, 0, 0);
    for (int i = 0; i < 5; i++) txw('h10 + i);
    chk("lb_ovf", 32'(ovf), 1);
    for (int i = 0; i < 4; i++) begin
      rxw('h10 + i);
      chk("lb_pop_match", 32'(match_pulse), 1);
    end
    rxw('h14);
    chk("lb_unexp", 32'(unexp), 1);
    chk("lb_unexp_err_cnt", 32'(err_cnt), 1);
    chk("lb_unexp_no_pulse", 32'(err_pulse), 0);

    // bypass on empty FIFO
    clr();
    both('hA5, 'hA5);
    chk("bypass_match", 32'(match_pulse), 1);
    rxw('h00);
    chk("bypass_no_push", 32'(unexp), 1);
    both('hA5, 'h5A);
    chk("bypass_err", 32'(err_pulse), 1);

    // saturation, clear with coincident error, reset mid-TRACK
    rst = 1; tick();
    wr(0, 'h41); wr(1, 'h42); wr(2, 'h43);
    do_arm(0, 1, 3);
    rxw('h41);
    for (int i = 0; i < 5; i++) rxw('h41);
    chk("sat_err_cnt", 32'(err_cnt), 3);
    clr_cnt = 1; rxw('h41);
    chk("clr_coincident", 32'(err_cnt), 1);
    rxw('h42);
    chk("track_idx", 32'(seq_idx), 2);
    rst = 1; tick();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_idx", 32'(seq_idx), 0);
    chk("rst_err_cnt", 32'(err_cnt), 0);

    // randomized mixed traffic
    do_arm(1, 0, 0);
    for (int i = 0; i < 1200; i++) begin
      if ($urandom_range(0, 399) == 0) rst = 1;
      if ($urandom_range(0, 39) == 0) begin
        arm = 1; mode = 1'($urandom_range(0, 1)); cont = 1'($urandom_range(0, 1));
        cfg_len = LW'($urandom_range(0, 5));
      end
      if ($urandom_range(0, 24) == 0) clr_cnt = 1;
      if ($urandom_range(0, 7) == 0) begin
        cfg_wr_en = 1; cfg_wr_addr = AW'($urandom_range(0, 3));
        cfg_wr_data = DW'('h41 + $urandom_range(0, 3));
      end
      tx_valid = 1'($urandom_range(0, 1));
      tx_data  = DW'($urandom_range(0, 3));
      rx_valid = 1'($urandom_range(0, 1));
      if (m_lb && q.size() > 0 && $urandom_range(0, 3) != 0) rx_data = q[0];
      else if (m_lb && $urandom_range(0, 1) == 0) rx_data = tx_data;
      else rx_data = DW'('h41 + $urandom_range(0, 3));
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
